// File: rtl/stream_mux_rr.sv
// N-to-1 valid/ready stream mux with a single-entry output register.
// Arbitration is fixed-priority or round-robin, with an optional forced channel.

module stream_mux_rr_lane #(
  parameter int IDX   = 0,
  parameter int SEL_W = 2
) (
  input  logic             valid,
  input  logic             force_en,
  input  logic [SEL_W-1:0] force_sel,
  output logic             elig
);
  // An out-of-range force_sel matches no lane, so the eligible set is empty.
  assign elig = valid & (!force_en | (force_sel == SEL_W'(IDX)));
endmodule

module stream_mux_rr #(
  parameter  int WIDTH    = 8,
  parameter  int CHANNELS = 4,
  parameter  int MODE     = 1,
  localparam int SEL_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  input  logic [CHANNELS-1:0]       in_valid,
  output logic [CHANNELS-1:0]       in_ready,
  input  logic                      force_en,
  input  logic [SEL_W-1:0]          force_sel,
  output logic [WIDTH-1:0]          out_data,
  output logic [SEL_W-1:0]          out_sel,
  output logic                      out_valid,
  input  logic                      out_ready
);
  typedef logic [SEL_W-1:0] sel_t;

  typedef struct packed {
    logic             valid;
    sel_t             sel;
    logic [WIDTH-1:0] data;
  } out_t;

  logic [CHANNELS-1:0][WIDTH-1:0] ch_data;
  logic [CHANNELS-1:0]            elig;
  logic                           load_en, xfer;
  sel_t                           gnt, rr_idx;
  sel_t                           ptr_q, ptr_d;
  out_t                           out_q, out_d;

  assign ch_data = in_data;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_lane
    stream_mux_rr_lane #(.IDX(i), .SEL_W(SEL_W)) u_lane (
      .valid    (in_valid[i]),
      .force_en (force_en),
      .force_sel(force_sel),
      .elig     (elig[i])
    );
  end

  assign load_en  = !out_q.valid | out_ready;
  assign xfer     = rst_n & load_en & (|elig);
  assign in_ready = xfer ? (CHANNELS'(1) << gnt) : '0;

  // Scan in descending search order so the last hit is the first in priority.
  always_comb begin
    gnt    = '0;
    rr_idx = '0;
    if (MODE == 0) begin
      for (int i = CHANNELS - 1; i >= 0; i--)
        if (elig[i]) gnt = sel_t'(i);
    end else begin
      for (int k = CHANNELS - 1; k >= 0; k--) begin
        rr_idx = sel_t'((int'(ptr_q) + k) % CHANNELS);
        if (elig[rr_idx]) gnt = rr_idx;
      end
    end
  end

  always_comb begin
    out_d       = out_q;
    out_d.valid = out_q.valid & !out_ready;
    ptr_d       = ptr_q;
    if (xfer) begin
      out_d.valid = 1'b1;
      out_d.sel   = gnt;
      out_d.data  = ch_data[gnt];
      ptr_d       = (int'(gnt) == CHANNELS - 1) ? '0 : gnt + sel_t'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q <= '0;
      ptr_q <= '0;
    end else begin
      out_q <= out_d;
      ptr_q <= ptr_d;
    end
  end

  assign out_data  = out_q.data;
  assign out_sel   = out_q.sel;
  assign out_valid = out_q.valid;
endmodule

// File: tb/tb_stream_mux_rr.sv
// Drives three mux builds (RR/4ch, fixed/4ch, RR/6ch) against a queue-free
// behavioural model that tracks the expected output register and pointer.
`timescale 1ns/1ps
module tb_stream_mux_rr;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic [5:0]  iv   [3];
  logic [47:0] id   [3];
  logic        fe   [3];
  logic [2:0]  fs   [3];
  logic        ordy [3];

  logic [3:0] ir0, ir1;
  logic [5:0] ir2;
  logic [7:0] od0, od1, od2;
  logic [1:0] os0, os1;
  logic [2:0] os2;
  logic       ov0, ov1, ov2;

  int total = 0;
  int bad   = 0;

  stream_mux_rr #(.WIDTH(8), .CHANNELS(4), .MODE(1)) u_rr4 (
    .clk(clk), .rst_n(rst_n), .in_data(id[0][31:0]), .in_valid(iv[0][3:0]),
    .in_ready(ir0), .force_en(fe[0]), .force_sel(fs[0][1:0]),
    .out_data(od0), .out_sel(os0), .out_valid(ov0), .out_ready(ordy[0]));

  stream_mux_rr #(.WIDTH(8), .CHANNELS(4), .MODE(0)) u_fp4 (
    .clk(clk), .rst_n(rst_n), .in_data(id[1][31:0]), .in_valid(iv[1][3:0]),
    .in_ready(ir1), .force_en(fe[1]), .force_sel(fs[1][1:0]),
    .out_data(od1), .out_sel(os1), .out_valid(ov1), .out_ready(ordy[1]));

  stream_mux_rr #(.WIDTH(8), .CHANNELS(6), .MODE(1)) u_rr6 (
    .clk(clk), .rst_n(rst_n), .in_data(id[2]), .in_valid(iv[2]),
    .in_ready(ir2), .force_en(fe[2]), .force_sel(fs[2]),
    .out_data(od2), .out_sel(os2), .out_valid(ov2), .out_ready(ordy[2]));

  // ---------------- behavioural model ----------------
  int         n    [3] = '{4, 4, 6};
  int         mode [3] = '{1, 0, 1};
  logic       mv   [3];
  logic [7:0] md   [3];
  int         ms   [3];
  int         mp   [3];

  function automatic logic [5:0] elig(int k);
    logic [5:0] v = iv[k] & 6'((1 << n[k]) - 1);
    int f = (n[k] == 4) ? int'(fs[k][1:0]) : int'(fs[k]);
    if (!fe[k]) return v;
    if (f < n[k] && v[f]) return 6'(1 << f);
    return '0;
  endfunction

  // Grant = eligible channel with the smallest priority distance.
  function automatic int gnt(int k);
    logic [5:0] e = elig(k);
    int best = 0, bd = 99, d;
    for (int i = 0; i < n[k]; i++) if (e[i]) begin
      d = (mode[k] == 0) ? i : (i - mp[k] + n[k]) % n[k];
      if (d < bd) begin bd = d; best = i; end
    end
    return best;
  endfunction

  function automatic int exp_ready(int k);
    if (!rst_n || elig(k) == 0 || (mv[k] && !ordy[k])) return 0;
    return 1 << gnt(k);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    for (int k = 0; k < 3; k++) begin
      if (!rst_n) begin
        mv[k] <= 1'b0; md[k] <= '0; ms[k] <= 0; mp[k] <= 0;
      end else if (exp_ready(k) != 0) begin
        mv[k] <= 1'b1;
        md[k] <= id[k][8*gnt(k) +: 8];
        ms[k] <= gnt(k);
        mp[k] <= (gnt(k) + 1) % n[k];
      end else if (ordy[k]) begin
        mv[k] <= 1'b0;
      end
    end
  end

  function automatic int get_ir(int k);
    case (k) 0: return int'(ir0); 1: return int'(ir1); default: return int'(ir2); endcase
  endfunction
  function automatic int get_od(int k);
    case (k) 0: return int'(od0); 1: return int'(od1); default: return int'(od2); endcase
  endfunction
  function automatic int get_os(int k);
    case (k) 0: return int'(os0); 1: return int'(os1); default: return int'(os2); endcase
  endfunction
  function automatic int get_ov(int k);
    case (k) 0: return int'(ov0); 1: return int'(ov1); default: return int'(ov2); endcase
  endfunction

  task automatic chk(string nm, int k, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s[%0d] t=%0t got=%0h want=%0h", nm, k, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      chk("ov",  k, get_ov(k), int'(mv[k]));
      chk("od",  k, get_od(k), int'(md[k]));
      chk("os",  k, get_os(k), ms[k]);
      chk("rdy", k, get_ir(k), exp_ready(k));
    end
  end

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  // ---------------- stimulus ----------------
  int rr_s [5] = '{0, 1, 2, 3, 0};
  int rr_d [5] = '{'hA0, 'hB1, 'hC2, 'hD3, 'hA0};

  initial begin
    for (int k = 0; k < 3; k++) begin
      iv[k] = '0; id[k] = '0; fe[k] = 1'b0; fs[k] = '0; ordy[k] = 1'b1;
    end
    #1 rst_n = 1'b0;
    iv[0] = 6'b001111;
    id[0] = 48'h0000_D3C2_B1A0;
    cyc(); cyc();
    chk("rst_ov", 0, int'(ov0), 0);
    chk("rst_od", 0, int'(od0), 0);
    chk("rst_os", 0, int'(os0), 0);
    chk("rst_ir", 0, int'(ir0), 0);
    #1 rst_n = 1'b1;

    for (int i = 0; i < 5; i++) begin
      cyc();
      chk("rr_ov", i, int'(ov0), 1);
      chk("rr_os", i, int'(os0), rr_s[i]);
      chk("rr_od", i, int'(od0), rr_d[i]);
    end

    iv[0] = 6'b000100; id[0] = 48'h0000_D35A_B1A0;
    cyc();
    chk("bp_os", 0, int'(os0), 2);
    chk("bp_od", 0, int'(od0), 'h5A);
    ordy[0] = 1'b0; iv[0] = 6'b001100; id[0] = 48'h0000_E75A_B1A0;
    #1 chk("bp_ir", 0, int'(ir0), 0);
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("bp_hold_od", i, int'(od0), 'h5A);
      chk("bp_hold_os", i, int'(os0), 2);
      chk("bp_hold_ov", i, int'(ov0), 1);
      chk("bp_hold_ir", i, int'(ir0), 0);
    end
    ordy[0] = 1'b1; iv[0] = 6'b001000;
    cyc();
    chk("bp_next_od", 0, int'(od0), 'hE7);
    chk("bp_next_os", 0, int'(os0), 3);
    chk("bp_next_ov", 0, int'(ov0), 1);

    fe[0] = 1'b1; fs[0] = 3'd2; iv[0] = 6'b001011;
    #1 chk("frc_ir", 0, int'(ir0), 0);
    cyc();
    chk("frc_drain", 0, int'(ov0), 0);
    iv[0] = 6'b001111; id[0] = 48'h0000_E7C2_B1A0;
    cyc();
    chk("frc_os", 0, int'(os0), 2);
    chk("frc_od", 0, int'(od0), 'hC2);
    fe[0] = 1'b0;
    cyc();
    chk("frc_after", 0, int'(os0), 3);

    iv[0] = 6'b000010;
    cyc();
    chk("ar_pre", 0, int'(os0), 1);
    ordy[0] = 1'b0; iv[0] = 6'b000110;
    cyc();
    #1 rst_n = 1'b0;
    #1 chk("ar_ov", 0, int'(ov0), 0);
    chk("ar_od", 0, int'(od0), 0);
    #1 rst_n = 1'b1;
    ordy[0] = 1'b1;
    cyc();
    chk("ar_ptr", 0, int'(os0), 1);
    iv[0] = '0;

    iv[1] = 6'b001010; id[1] = 48'h0000_4433_2211;
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk("fp_os", i, int'(os1), 1);
      chk("fp_od", i, int'(od1), 'h22);
      chk("fp_ir3", i, int'(ir1[3]), 0);
    end
    iv[1] = 6'b001000;
    cyc();
    chk("fp_drop", 0, int'(os1), 3);
    chk("fp_drop_od", 0, int'(od1), 'h44);
    iv[1] = '0;

    id[2] = 48'h5F4E_3D2C_1B0A;
    fe[2] = 1'b1; fs[2] = 3'd5; iv[2] = 6'b011111;
    #1 chk("c6_ir", 0, int'(ir2), 0);
    cyc();
    chk("c6_nogrant", 0, int'(ov2), 0);
    fs[2] = 3'd6; iv[2] = 6'b111111;
    #1 chk("c6_oor_ir", 0, int'(ir2), 0);
    cyc();
    chk("c6_oor", 0, int'(ov2), 0);
    fs[2] = 3'd5;
    cyc();
    chk("c6_frc_os", 0, int'(os2), 5);
    chk("c6_frc_od", 0, int'(od2), 'h5F);
    fe[2] = 1'b0;
    cyc();
    chk("c6_wrap", 0, int'(os2), 0);
    chk("c6_wrap_od", 0, int'(od2), 'h0A);

    for (int c = 0; c < 3000; c++) begin
      for (int k = 0; k < 3; k++) begin
        iv[k]   = 6'($urandom) & 6'($urandom | $urandom);
        id[k]   = {16'($urandom), 32'($urandom)};
        fe[k]   = ($urandom_range(0, 7) == 0);
        fs[k]   = 3'($urandom);
        ordy[k] = ($urandom_range(0, 3) != 0);
      end
      cyc();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
